// File: rtl/muldiv_ctrl.sv
// HI/LO owner and ABP initiator for the multiplier and divider units.
// Dispatches MULT/MULTU/DIV/DIVU, handles MTHI/MTLO and divide-by-zero locally, and times out lost acks.
module muldiv_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic        sys_clock_i,
  input  logic        sys_reset_i,
  input  logic        op_valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        op_ready_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  output logic        mul_signed_o,
  output logic        mul_req_o,
  input  logic        mul_ack_i,
  input  logic [63:0] mul_product_i,
  output logic [31:0] div_a_o,
  output logic [31:0] div_b_o,
  output logic        div_signed_o,
  output logic        div_req_o,
  input  logic        div_ack_i,
  input  logic [31:0] div_quotient_i,
  input  logic [31:0] div_remainder_i
);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DRAIN} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic             ready_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             mul_idle, div_idle;
  logic             start_mul, start_div, div_zero, wr_hi, wr_lo;
  logic             cap_mul, cap_div, time_out;

  assign accept     = op_valid_i && ready_q;
  assign mul_idle   = (mul_ack_i == mul_req_o);
  assign div_idle   = (div_ack_i == div_req_o);
  assign op_ready_o = ready_q;

  always_comb begin
    state_d   = state_q;
    start_mul = 1'b0;
    start_div = 1'b0;
    div_zero  = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    cap_mul   = 1'b0;
    cap_div   = 1'b0;
    time_out  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op_i)
            3'b000, 3'b001: begin
              start_mul = 1'b1;
              state_d   = MUL_WAIT;
            end
            3'b010, 3'b011: begin
              if (b_i == '0) begin
                div_zero = 1'b1;
              end else begin
                start_div = 1'b1;
                state_d   = DIV_WAIT;
              end
            end
            3'b100:  wr_hi = 1'b1;
            3'b101:  wr_lo = 1'b1;
            default: ;
          endcase
        end
      end
      // An ack arriving in the timeout cycle is taken as a normal completion.
      MUL_WAIT: begin
        if (mul_idle) begin
          cap_mul = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == TIMEOUT_C) begin
          time_out = 1'b1;
          state_d  = DRAIN;
        end
      end
      DIV_WAIT: begin
        if (div_idle) begin
          cap_div = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == TIMEOUT_C) begin
          time_out = 1'b1;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (mul_idle && div_idle) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clock_i or negedge sys_reset_i) begin
    if (!sys_reset_i) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      cnt_q        <= '0;
      hi_o         <= '0;
      lo_o         <= '0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      mul_a_o      <= '0;
      mul_b_o      <= '0;
      mul_signed_o <= 1'b0;
      mul_req_o    <= 1'b0;
      div_a_o      <= '0;
      div_b_o      <= '0;
      div_signed_o <= 1'b0;
      div_req_o    <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      done_o  <= cap_mul || cap_div || div_zero;

      if (accept) begin
        err_o <= 1'b0;
        cnt_q <= '0;
      end else begin
        if (time_out) err_o <= 1'b1;
        if (state_q == MUL_WAIT || state_q == DIV_WAIT) cnt_q <= cnt_q + CNT_W'(1);
      end

      if (start_mul) begin
        mul_a_o      <= a_i;
        mul_b_o      <= b_i;
        mul_signed_o <= ~op_i[0];
        mul_req_o    <= ~mul_req_o;
      end
      if (start_div) begin
        div_a_o      <= a_i;
        div_b_o      <= b_i;
        div_signed_o <= ~op_i[0];
        div_req_o    <= ~div_req_o;
      end

      if (cap_mul) begin
        hi_o <= mul_product_i[63:32];
        lo_o <= mul_product_i[31:0];
      end
      if (cap_div) begin
        hi_o <= div_remainder_i;
        lo_o <= div_quotient_i;
      end
      if (div_zero) begin
        hi_o <= a_i;
        lo_o <= '1;
      end
      if (wr_hi) hi_o <= a_i;
      if (wr_lo) lo_o <= a_i;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: behavioural 32-cycle multiplier/divider responders, a directed
// vector table, randomized ops against an arithmetic HI/LO model, timeout and reset sequences.
module tb_muldiv_ctrl;
  localparam int unsigned TIMEOUT = 64;
  localparam int          LAT     = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'b110;
  logic [31:0] a = '0, b = '0;
  logic        op_ready, done, err;
  logic [31:0] hi, lo;
  logic [31:0] mul_a, mul_b, div_a, div_b;
  logic        mul_signed, mul_req, div_signed, div_req;
  logic        mul_ack, div_ack;
  logic [63:0] mul_product;
  logic [31:0] div_q, div_r;
  logic        mul_hang = 1'b0;
  int          mul_cnt, div_cnt;

  always #5 clk = ~clk;

  muldiv_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .sys_clock_i(clk), .sys_reset_i(rst_n),
    .op_valid_i(op_valid), .op_i(op), .a_i(a), .b_i(b),
    .op_ready_o(op_ready), .hi_o(hi), .lo_o(lo), .done_o(done), .err_o(err),
    .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_signed_o(mul_signed),
    .mul_req_o(mul_req), .mul_ack_i(mul_ack), .mul_product_i(mul_product),
    .div_a_o(div_a), .div_b_o(div_b), .div_signed_o(div_signed),
    .div_req_o(div_req), .div_ack_i(div_ack),
    .div_quotient_i(div_q), .div_remainder_i(div_r)
  );

  // Responders: answer LAT cycles after seeing a new request level.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_ack <= 1'b0; mul_cnt <= 0; mul_product <= '0;
    end else if (mul_req != mul_ack && !mul_hang) begin
      if (mul_cnt == LAT - 1) begin
        mul_ack <= mul_req;
        mul_cnt <= 0;
        if (mul_signed)
          mul_product <= $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});
        else
          mul_product <= {32'd0, mul_a} * {32'd0, mul_b};
      end else mul_cnt <= mul_cnt + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_ack <= 1'b0; div_cnt <= 0; div_q <= '0; div_r <= '0;
    end else if (div_req != div_ack) begin
      if (div_cnt == LAT - 1) begin
        div_ack <= div_req;
        div_cnt <= 0;
        if (div_signed) begin
          div_q <= $signed(div_a) / $signed(div_b);
          div_r <= $signed(div_a) % $signed(div_b);
        end else begin
          div_q <= div_a / div_b;
          div_r <= div_a % div_b;
        end
      end else div_cnt <= div_cnt + 1;
    end
  end

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Architectural HI/LO model.
  logic [31:0] m_hi = '0, m_lo = '0;

  task automatic model_apply(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                             output logic exp_done);
    int          sa, sb;
    longint      sp;
    logic [63:0] up;
    sa = ma; sb = mb;
    exp_done = 1'b0;
    case (mop)
      3'b000: begin sp = longint'(sa) * longint'(sb); {m_hi, m_lo} = sp; exp_done = 1'b1; end
      3'b001: begin up = {32'd0, ma} * {32'd0, mb}; {m_hi, m_lo} = up; exp_done = 1'b1; end
      3'b010, 3'b011: begin
        exp_done = 1'b1;
        if (mb == 0) begin m_hi = ma; m_lo = 32'hFFFF_FFFF; end
        else if (mop == 3'b010) begin m_lo = sa / sb; m_hi = sa % sb; end
        else begin m_lo = ma / mb; m_hi = ma % mb; end
      end
      3'b100: m_hi = ma;
      3'b101: m_lo = ma;
      default: ;
    endcase
  endtask

  // Issue one op from a negedge; returns at the negedge where op_ready is seen again.
  task automatic run_op(input logic [2:0] top, input logic [31:0] ta, input logic [31:0] tb_,
                        input bit junk, output logic done_seen, output int lat,
                        output logic mtog, output logic dtog);
    logic mreq0, dreq0;
    int   n;
    n = 0;
    while (!op_ready && n < 100) begin @(negedge clk); n++; end
    if (!op_ready) check("ready_wait", {63'd0, op_ready}, 64'd1);
    mreq0 = mul_req; dreq0 = div_req;
    op_valid = 1'b1; op = top; a = ta; b = tb_;
    @(negedge clk);
    op_valid = 1'b0;
    lat = 1;
    done_seen = done;
    while (!op_ready && lat < 60) begin
      if (junk) begin op_valid = 1'b1; op = 3'b100; a = $urandom; end
      @(negedge clk);
      op_valid = 1'b0;
      lat++;
      if (done) done_seen = 1'b1;
    end
    if (!op_ready) check("complete_wait", {63'd0, op_ready}, 64'd1);
    mtog = (mul_req != mreq0);
    dtog = (div_req != dreq0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        done;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic ds, mt, dt, exp_done, uses_unit;
    int   lat, n;
    logic [31:0] hi0, lo0;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    vecs[0] = '{3'b001, 32'd17,         32'd3,          32'h0000_0000, 32'd51,         1'b1};
    vecs[1] = '{3'b000, 32'hFFFF_FFF9, 32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1};
    vecs[2] = '{3'b011, 32'd17,         32'd5,          32'd2,         32'd3,          1'b1};
    vecs[3] = '{3'b010, 32'd20,         32'd0,          32'd20,        32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{3'b100, 32'd5,          32'd0,          32'd5,         32'hFFFF_FFFF, 1'b0};
    vecs[5] = '{3'b101, 32'd9,          32'd0,          32'd5,         32'd9,          1'b0};
    vecs[6] = '{3'b110, 32'd123,        32'd45,         32'd5,         32'd9,          1'b0};
    vecs[7] = '{3'b010, 32'hFFFF_FFEF, 32'd5,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1};
    vecs[8] = '{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1};
    vecs[9] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1};

    // Reset state
    #12;
    check("rst_outs", {hi, lo}, 64'd0);
    check("rst_ctl", {58'd0, op_ready, done, err, mul_req, div_req, mul_signed}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {63'd0, op_ready}, 64'd1);

    // Directed table; ops issued back-to-back as soon as ready returns
    for (int i = 0; i < 10; i++) begin
      uses_unit = (vecs[i].op[2:1] == 2'b00) || (vecs[i].op[2:1] == 2'b01 && vecs[i].b != 0);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, (i == 0), ds, lat, mt, dt);
      check($sformatf("vec%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].hi});
      check($sformatf("vec%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].lo});
      check($sformatf("vec%0d_done", i), {63'd0, ds}, {63'd0, vecs[i].done});
      check($sformatf("vec%0d_mtog", i), {63'd0, mt}, {63'd0, vecs[i].op[2:1] == 2'b00});
      check($sformatf("vec%0d_dtog", i), {63'd0, dt},
            {63'd0, vecs[i].op[2:1] == 2'b01 && vecs[i].b != 0});
      if (uses_unit) check($sformatf("vec%0d_lat", i), {63'd0, lat >= 34 && lat <= 36}, 64'd1);
      else check($sformatf("vec%0d_lat", i), lat, 64'd1);
    end
    m_hi = vecs[9].hi; m_lo = vecs[9].lo;

    // Randomized ops against the model, with ignored offers during waits
    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 6));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      if (rop == 3'b010 && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
      model_apply(rop, ra, rb, exp_done);
      run_op(rop, ra, rb, $urandom_range(0, 1) == 1, ds, lat, mt, dt);
      check($sformatf("rnd%0d_hilo op=%0d", i, rop), {hi, lo}, {m_hi, m_lo});
      check($sformatf("rnd%0d_done", i), {63'd0, ds}, {63'd0, exp_done});
    end

    // Timeout: multiplier withholds ack, then answers late
    hi0 = hi; lo0 = lo;
    mul_hang = 1'b1;
    op_valid = 1'b1; op = 3'b000; a = 32'd2; b = 32'd3;
    @(negedge clk);
    op_valid = 1'b0;
    n = 1; ds = done;
    while (!err && n < TIMEOUT + 10) begin @(negedge clk); n++; ds |= done; end
    check("to_err", {63'd0, err}, 64'd1);
    check("to_time", {63'd0, n >= TIMEOUT && n <= TIMEOUT + 3}, 64'd1);
    check("to_ready_low", {63'd0, op_ready}, 64'd0);
    while (n < 70) begin @(negedge clk); n++; ds |= done; end
    mul_hang = 1'b0;
    n = 0;
    while (!op_ready && n < 60) begin @(negedge clk); n++; ds |= done; end
    check("drain_ready", {63'd0, op_ready}, 64'd1);
    check("drain_no_done", {63'd0, ds}, 64'd0);
    check("drain_hilo", {hi, lo}, {hi0, lo0});
    check("drain_err_sticky", {63'd0, err}, 64'd1);
    model_apply(3'b100, 32'hABCD, 32'd0, exp_done);
    run_op(3'b100, 32'hABCD, 32'd0, 1'b0, ds, lat, mt, dt);
    check("err_cleared", {63'd0, err}, 64'd0);
    check("mthi_after_to", {hi, lo}, {m_hi, m_lo});

    // Reset in the middle of a divide
    op_valid = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_hilo", {hi, lo}, 64'd0);
    check("midrst_ctl", {58'd0, op_ready, done, err, mul_req, div_req, div_signed}, 64'd0);
    check("midrst_opnd", {div_a, div_b}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", {63'd0, op_ready}, 64'd1);
    run_op(3'b011, 32'd17, 32'd5, 1'b0, ds, lat, mt, dt);
    check("post_rst_divu", {hi, lo}, {32'd2, 32'd3});
    check("post_rst_done", {63'd0, ds}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end
endmodule
